// File: rtl/muldiv_pkg.sv
// Shared types, multiplier op encodings and op-class helpers for the
// multiply/divide HI/LO controller.
package muldiv_pkg;

    typedef enum logic [3:0] {
        NONE  = 4'd0,
        MULT  = 4'd1,
        MULTU = 4'd2,
        MADD  = 4'd3,
        MADDU = 4'd4,
        MSUB  = 4'd5,
        MSUBU = 4'd6,
        MTHI  = 4'd7,
        MTLO  = 4'd8
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } ctrl_state_t;

    localparam logic [1:0] MUL_SIGNED   = 2'b10;
    localparam logic [1:0] MUL_UNSIGNED = 2'b01;
    localparam logic [1:0] MUL_NONE     = 2'b00;

    // Ops that go through the multiplier and update HI/LO from its product.
    function automatic logic is_mulclass(input muldiv_op_t op);
        return (op == MULT) || (op == MULTU) || (op == MADD) ||
               (op == MADDU) || (op == MSUB) || (op == MSUBU);
    endfunction

    // Ops whose operands are treated as two's complement.
    function automatic logic is_signed(input muldiv_op_t op);
        return (op == MULT) || (op == MADD) || (op == MSUB);
    endfunction

endpackage

// File: rtl/muldiv_hilo_ctrl.sv
// Issue/retire controller between EX and the external 4-stage multiplier.
// Issues one multiply at a time, stalls EX until the product is back, and
// folds the product into the architectural HI/LO pair (write, add or sub).
module muldiv_hilo_ctrl
    import muldiv_pkg::*;
#(
    parameter int MUL_LAT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        flush,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [1:0]  mul_op,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [63:0] mul_c,
    input  logic        mul_done
);

    ctrl_state_t state, state_nxt;
    muldiv_op_t  req_kind, op_q;
    logic [31:0] a_q, b_q;
    logic        discard, seen_busy;
    logic        req_mul, req_mthi, req_mtlo, req_move, finish;
    logic [63:0] hilo, acc_nxt;
    logic [7:0]  busy_cnt;

    assign req_kind = muldiv_op_t'(req_op);
    assign req_mul  = req_valid && !flush && is_mulclass(req_kind);
    assign req_mthi = req_valid && !flush && (req_kind == MTHI);
    assign req_mtlo = req_valid && !flush && (req_kind == MTLO);
    assign req_move = req_mthi || req_mtlo;
    // mul_done alone is not enough: it is also high before the multiplier
    // has picked up the op, so we need to have seen it go busy first.
    assign finish   = (state == WAIT) && mul_done && seen_busy;
    assign hilo     = {hi, lo};

    // Next-state logic: single outstanding multiply, one issue cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_mul) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (finish) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Multiplier drive and EX stall; everything is quiet while in reset.
    always_comb begin
        mul_op = MUL_NONE;
        mul_a  = '0;
        mul_b  = '0;
        stall  = 1'b0;
        if (rst_n) begin
            if (state == ISSUE) begin
                mul_op = is_signed(op_q) ? MUL_SIGNED : MUL_UNSIGNED;
                mul_a  = a_q;
                mul_b  = b_q;
            end
            stall = (req_mul && !(finish && !discard)) ||
                    (req_move && (state != IDLE));
        end
    end

    // HI/LO update value for the op currently in flight.
    always_comb begin
        acc_nxt = mul_c;
        case (op_q)
            MADD, MADDU: acc_nxt = hilo + mul_c;
            MSUB, MSUBU: acc_nxt = hilo - mul_c;
            default:     acc_nxt = mul_c;
        endcase
    end

    // Operand capture at accept time; only meaningful while in ISSUE/WAIT.
    always_ff @(posedge clk) begin
        if (state == IDLE && req_mul) begin
            op_q <= req_kind;
            a_q  <= req_a;
            b_q  <= req_b;
        end
    end

    // State register, HI/LO, and drain/discard bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            hi        <= '0;
            lo        <= '0;
            discard   <= 1'b0;
            seen_busy <= 1'b0;
            busy_cnt  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (req_mthi)      hi <= req_a;
                    else if (req_mtlo) lo <= req_a;
                end
                ISSUE: begin
                    seen_busy <= 1'b0;
                    busy_cnt  <= '0;
                    if (flush) discard <= 1'b1;
                end
                WAIT: begin
                    if (!mul_done) begin
                        seen_busy <= 1'b1;
                        busy_cnt  <= busy_cnt + 8'd1;
                    end
                    if (finish) begin
                        discard <= 1'b0;
                        // A flush landing on the finish cycle also kills the result.
                        if (!discard && !flush) {hi, lo} <= acc_nxt;
                    end else if (flush) begin
                        discard <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // The multiplier must go busy on the first WAIT cycle.
    a_seen_busy: assert property (@(posedge clk) disable iff (!rst_n)
        (state == WAIT && !seen_busy) |=> !(state == WAIT && !seen_busy));

    // Busy time observed in WAIT must match the multiplier depth.
    a_latency: assert property (@(posedge clk) disable iff (!rst_n)
        finish |-> (busy_cnt == 8'(MUL_LAT)));

endmodule

// File: doc/muldiv_hilo_ctrl.md
Name: muldiv_hilo_ctrl

Overview:
- Issue/retire controller between the EX stage and the 4-stage multiplier.
- Accepts MULT/MULTU/MADD/MADDU/MSUB/MSUBU/MTHI/MTLO requests, drives the multiplier's op/a/b inputs and stalls the pipeline while the multiplier is busy.
- Accumulates the 64-bit product into architectural HI/LO.
- Handles flush of an in-flight multiply by draining it and discarding the result.

Parameters:
MUL_LAT, 4, multiplier pipeline depth; used only for assertions, since completion is detected from mul_done.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset, sampled on posedge clk
req_valid  in  1  EX-stage request valid; held stable by the pipeline while stall=1
req_op  in  4  operation code (package enum)
req_a  in  32  rs operand
req_b  in  32  rt operand
flush  in  1  exception/redirect; kills the current request and any in-flight result
stall  out  1  pipeline must hold the EX stage
hi  out  32  architectural HI
lo  out  32  architectural LO
mul_op  out  2  to multiplier: 2'b10 signed, 2'b01 unsigned, 2'b00 none
mul_a  out  32  to multiplier operand a
mul_b  out  32  to multiplier operand b
mul_c  in  64  product from multiplier, sign already applied
mul_done  in  1  multiplier idle/result-valid, high when counter is zero

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=IDLE; hi=lo=0; discard=0; seen_busy=0.
  - mul_op=00, mul_a=mul_b=0.
  - stall=0 during reset.
  - Reset mid-operation abandons the op. The multiplier is reset by the same reset net, inverted at top level.
- Op classes:
  - MULCLASS = MULT, MULTU, MADD, MADDU, MSUB, MSUBU.
  - MOVE = MTHI, MTLO.
  - NOP = any other code, ignored.
- State IDLE:
  - req_valid && !flush && MULCLASS: latch op, a, b; go to ISSUE.
  - req_valid && !flush && MTHI: hi<=req_a at the next edge; no stall. MTLO writes lo the same way.
- State ISSUE (exactly one cycle):
  - Drive mul_op from the latched op (signed ops -> 10, unsigned -> 01) with mul_a/mul_b = latched a/b.
  - Clear seen_busy; go to WAIT.
  - mul_op is 00 in every other state.
- State WAIT:
  - mul_done=0 sets seen_busy.
  - mul_done && seen_busy is the finish condition. On finish, write HI/LO at the edge unless discard, then return to IDLE and clear discard:
    - MULT/MULTU: {hi,lo} <= mul_c.
    - MADD/MADDU: {hi,lo} <= {hi,lo} + mul_c (64-bit, wraps modulo 2^64).
    - MSUB/MSUBU: {hi,lo} <= {hi,lo} - mul_c (wraps).
- Stall, combinational:
  - stall = req_valid && !flush && ((MULCLASS && !(WAIT && finish && !discard)) || (MOVE && state!=IDLE)).
  - NOP never stalls.
- Latency, measured from request cycle T0 for a MULCLASS op in IDLE:
  - stall=1 in T0..T5; stall=0 in T6 (finish).
  - HI/LO are updated and visible from T7.
  - Total: 7 cycles, 6 stall cycles.
- Flush:
  - Flush in IDLE: the request is ignored.
  - Flush in ISSUE or WAIT: set discard. The multiplier cannot be cancelled, so the unit drains to the finish condition without writing HI/LO.
  - stall is forced to 0 during flush.
  - A new MULCLASS or MOVE request arriving while draining stalls until IDLE, then proceeds normally.
- Simultaneous events:
  - MOVE arriving in the finish cycle stalls (state!=IDLE) and executes the next cycle, so its write follows the product write.
  - flush wins over req_valid.
  - rst_n wins over everything.
- Assertion: seen_busy must not remain 0 for more than 1 WAIT cycle. Count of WAIT cycles with mul_done=0 equals MUL_LAT.

Decomposition:
- Package muldiv_pkg holds:
  - typedef enum logic [3:0] muldiv_op_t: NONE=0, MULT, MULTU, MADD, MADDU, MSUB, MSUBU, MTHI, MTLO.
  - typedef enum ctrl_state_t: IDLE, ISSUE, WAIT.
  - Constants MUL_SIGNED=2'b10, MUL_UNSIGNED=2'b01, MUL_NONE=2'b00.
  - Helper functions is_mulclass() and is_signed().
- No sub-module. The HI/LO accumulator is inline.
- The multiplier is instantiated beside this block at the EX-stage top, not inside it.

Test Plan:
- MULT a=0xFFFFFFFF b=0x00000002, mul model 4-cycle -> stall high exactly T0..T5; hi=0xFFFFFFFF, lo=0xFFFFFFFE from T7; mul_op=10 only in T1.
- MULTU same operands -> mul_op=01; hi=0x00000001, lo=0xFFFFFFFE.
- MTHI 0x12345678, MTLO 0x00000010, then MADDU a=0x10 b=0x10 -> hi=0x12345678, lo=0x00000110. Then MSUB a=1 b=0x111 -> hi=0x12345677, lo=0xFFFFFFFF.
- MULT 3x3, flush asserted in T3 -> stall drops in T3; HI/LO unchanged. MTLO 5 issued at T4 stalls until IDLE (T7), then lo=5.
- MULT in flight, rst_n=0 at T3 -> next cycle hi=lo=0, state IDLE, stall=0, mul_op=00. A fresh MULT 2x2 afterwards -> lo=4.
- MTHI arriving in the finish cycle of MULT 7x7 -> lo=49, hi is the MTHI value, written one cycle after the product.
